// File: rtl/rgb_to_yuv_encoder_pkg.sv
// Shared types and constants for the RGB to YUV 4:2:2 encoder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rgb_to_yuv_encoder_pkg;

    typedef enum logic [3:0] {
        S_ENC_IDLE,
        S_ENC_RD0,
        S_ENC_RD1,
        S_ENC_RD2,
        S_ENC_CAP1,
        S_ENC_CAP2,
        S_ENC_CY0,
        S_ENC_CU0,
        S_ENC_CV0,
        S_ENC_CY1,
        S_ENC_CU1,
        S_ENC_CV1,
        S_ENC_WR_Y,
        S_ENC_WR_U,
        S_ENC_WR_V
    } enc_state_t;

    localparam logic [17:0] Y_BASE   = 18'd0;
    localparam logic [17:0] U_BASE   = 18'd38400;
    localparam logic [17:0] V_BASE   = 18'd57600;
    localparam logic [17:0] RGB_BASE = 18'd146944;

    typedef struct packed {
        logic signed [17:0] c1;
        logic signed [17:0] c2;
        logic signed [17:0] c3;
        logic        [7:0]  offset;
    } coef_t;

    // BT.601 in Q16, applied to R, G, B in that order
    localparam coef_t COEF_Y = '{c1: 18'sd16843,  c2: 18'sd33030,  c3: 18'sd6423,  offset: 8'd16};
    localparam coef_t COEF_U = '{c1: -18'sd9699,  c2: -18'sd19071, c3: 18'sd28770, offset: 8'd128};
    localparam coef_t COEF_V = '{c1: 18'sd28770,  c2: -18'sd24117, c3: -18'sd4653, offset: 8'd128};

endpackage

// File: rtl/rgb_to_yuv_encoder_if.sv
// Single-port SRAM bus shared with the top-level arbiter.
// Latency: read data valid two edges after the address is registered.
// Backpressure: none; the owner of the port drives it every cycle.
interface rgb_to_yuv_encoder_if;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_read_data;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    modport master (output SRAM_address, output SRAM_write_data, output SRAM_we_n,
                    input  SRAM_read_data);
    modport slave  (input  SRAM_address, input  SRAM_write_data, input  SRAM_we_n,
                    output SRAM_read_data);
endinterface

// File: rtl/rgb_to_yuv_encoder_component.sv
// One YUV component from an RGB pixel: rounded Q16 dot product, offset, clamp.
// Latency: combinational.
// Backpressure: none.
module rgb_to_yuv_encoder_component
    import rgb_to_yuv_encoder_pkg::*;
(
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    input  coef_t      coef,
    output logic [7:0] result
);

    logic signed [31:0] c1_ext, c2_ext, c3_ext;
    logic signed [31:0] r_ext, g_ext, b_ext;
    logic signed [31:0] sum, scaled, biased;

    always_comb begin
        c1_ext = 32'($signed(coef.c1));
        c2_ext = 32'($signed(coef.c2));
        c3_ext = 32'($signed(coef.c3));
        r_ext  = {24'd0, r};
        g_ext  = {24'd0, g};
        b_ext  = {24'd0, b};
        sum    = c1_ext * r_ext + c2_ext * g_ext + c3_ext * b_ext + 32'sd32768;
        // arithmetic shift floors negative chroma terms
        scaled = sum >>> 16;
        biased = scaled + $signed({24'd0, coef.offset});
        if (biased < 32'sd0) begin
            result = 8'd0;
        end else if (biased > 32'sd255) begin
            result = 8'd255;
        end else begin
            result = biased[7:0];
        end
    end

endmodule

// File: rtl/rgb_to_yuv_encoder.sv
// RGB image to packed YUV 4:2:2 over the shared SRAM; RGB2YUV_AVG_EN selects averaged U/V, else even-pixel sampling.
// Latency: 12 cycles per even pair, 14 per odd pair; Done pulses after the last V write.
// Backpressure: none; owns the SRAM port for the whole image, Enable ignored while busy.
module rgb_to_yuv_encoder
    import rgb_to_yuv_encoder_pkg::*;
#(
    parameter logic [16:0] NUM_PAIRS = 17'd38400
)(
    input  logic                        Clock,
    input  logic                        Resetn,
    input  logic                        Enable,
    output logic                        Done,
    rgb_to_yuv_encoder_if.master        sram
);

    localparam logic [16:0] LAST_P = NUM_PAIRS - 17'd1;

    enc_state_t  state, state_nxt;
    logic [16:0] p;
    logic [17:0] rgb_ptr;
    logic [17:0] addr_nxt;
    logic [15:0] wdata_nxt;
    logic        we_n_nxt, done_nxt;
    logic        start, advance, pair_done, use_pix1;
    coef_t       coef;

    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic [7:0] y0, y1, u0, v0, u_hi, v_hi;
    logic [7:0] r_sel, g_sel, b_sel, comp;
    logic [7:0] u_out, v_out;

    assign r_sel = use_pix1 ? r1 : r0;
    assign g_sel = use_pix1 ? g1 : g0;
    assign b_sel = use_pix1 ? b1 : b0;

    rgb_to_yuv_encoder_component u_comp (
        .r      (r_sel),
        .g      (g_sel),
        .b      (b_sel),
        .coef   (coef),
        .result (comp)
    );

`ifdef RGB2YUV_AVG_EN
    logic [7:0] u1, v1;
    assign u_out = 8'(({1'b0, u0} + {1'b0, u1} + 9'd1) >> 1);
    assign v_out = 8'(({1'b0, v0} + {1'b0, v1} + 9'd1) >> 1);
`else
    assign u_out = u0;
    assign v_out = v0;
`endif

    always_comb begin
        state_nxt = state;
        addr_nxt  = sram.SRAM_address;
        wdata_nxt = sram.SRAM_write_data;
        we_n_nxt  = 1'b1;
        done_nxt  = 1'b0;
        start     = 1'b0;
        advance   = 1'b0;
        pair_done = 1'b0;
        use_pix1  = 1'b0;
        coef      = COEF_Y;
        case (state)
            // Done's own cycle must not retrigger a new image
            S_ENC_IDLE: if (Enable && !Done) begin
                start     = 1'b1;
                addr_nxt  = RGB_BASE;
                state_nxt = S_ENC_RD0;
            end
            S_ENC_RD0: begin addr_nxt = rgb_ptr + 18'd1; state_nxt = S_ENC_RD1; end
            S_ENC_RD1: begin addr_nxt = rgb_ptr + 18'd2; state_nxt = S_ENC_RD2; end
            S_ENC_RD2:  state_nxt = S_ENC_CAP1;
            S_ENC_CAP1: state_nxt = S_ENC_CAP2;
            S_ENC_CAP2: state_nxt = S_ENC_CY0;
            S_ENC_CY0:  begin coef = COEF_Y; state_nxt = S_ENC_CU0; end
            S_ENC_CU0:  begin coef = COEF_U; state_nxt = S_ENC_CV0; end
            S_ENC_CV0:  begin coef = COEF_V; state_nxt = S_ENC_CY1; end
            S_ENC_CY1:  begin coef = COEF_Y; use_pix1 = 1'b1; state_nxt = S_ENC_CU1; end
            S_ENC_CU1:  begin coef = COEF_U; use_pix1 = 1'b1; state_nxt = S_ENC_CV1; end
            S_ENC_CV1: begin
                coef      = COEF_V;
                use_pix1  = 1'b1;
                addr_nxt  = Y_BASE + 18'(p);
                wdata_nxt = {y0, y1};
                we_n_nxt  = 1'b0;
                state_nxt = S_ENC_WR_Y;
            end
            S_ENC_WR_Y: if (p[0]) begin
                addr_nxt  = U_BASE + 18'(p >> 1);
                wdata_nxt = {u_hi, u_out};
                we_n_nxt  = 1'b0;
                state_nxt = S_ENC_WR_U;
            end else begin
                pair_done = 1'b1;
            end
            S_ENC_WR_U: begin
                addr_nxt  = V_BASE + 18'(p >> 1);
                wdata_nxt = {v_hi, v_out};
                we_n_nxt  = 1'b0;
                state_nxt = S_ENC_WR_V;
            end
            S_ENC_WR_V: pair_done = 1'b1;
            default:    state_nxt = S_ENC_IDLE;
        endcase

        if (pair_done) begin
            if (p == LAST_P) begin
                done_nxt  = 1'b1;
                state_nxt = S_ENC_IDLE;
            end else begin
                advance   = 1'b1;
                addr_nxt  = rgb_ptr + 18'd3;
                state_nxt = S_ENC_RD0;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state                <= S_ENC_IDLE;
            p                    <= '0;
            rgb_ptr              <= '0;
            sram.SRAM_address    <= '0;
            sram.SRAM_write_data <= '0;
            sram.SRAM_we_n       <= 1'b1;
            Done                 <= 1'b0;
            {r0, g0, b0, r1, g1, b1} <= '0;
            {y0, y1, u0, v0, u_hi, v_hi} <= '0;
`ifdef RGB2YUV_AVG_EN
            {u1, v1} <= '0;
`endif
        end else begin
            state                <= state_nxt;
            sram.SRAM_address    <= addr_nxt;
            sram.SRAM_write_data <= wdata_nxt;
            sram.SRAM_we_n       <= we_n_nxt;
            Done                 <= done_nxt;
            if (start) begin
                p       <= '0;
                rgb_ptr <= RGB_BASE;
            end else if (advance) begin
                p       <= p + 17'd1;
                rgb_ptr <= rgb_ptr + 18'd3;
            end
            case (state)
                S_ENC_RD2:  {r0, g0} <= sram.SRAM_read_data;
                S_ENC_CAP1: {b0, r1} <= sram.SRAM_read_data;
                S_ENC_CAP2: {g1, b1} <= sram.SRAM_read_data;
                S_ENC_CY0:  y0 <= comp;
                S_ENC_CU0:  u0 <= comp;
                S_ENC_CV0:  v0 <= comp;
                S_ENC_CY1:  y1 <= comp;
`ifdef RGB2YUV_AVG_EN
                S_ENC_CU1:  u1 <= comp;
                S_ENC_CV1:  v1 <= comp;
`endif
                S_ENC_WR_Y: if (!p[0]) begin
                    u_hi <= u_out;
                    v_hi <= v_out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_to_yuv_encoder.sv
// Directed bench for rgb_to_yuv_encoder on a 4-pair image with a two-edge-latency SRAM model.
module tb_rgb_to_yuv_encoder;
    import rgb_to_yuv_encoder_pkg::*;

    localparam int NP = 4;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;
    logic Enable = 1'b0;
    logic Done;

    rgb_to_yuv_encoder_if sram();

    rgb_to_yuv_encoder #(.NUM_PAIRS(17'd4)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Enable (Enable),
        .Done   (Done),
        .sram   (sram)
    );

    always #5 Clock = ~Clock;

    logic [15:0] mem [0:262143];
    logic [17:0] rd_q;
    logic        pl_vld  = 1'b0;
    logic [17:0] pl_addr = '0;
    logic [15:0] pl_dat  = '0;

    always @(posedge Clock) begin
        rd_q <= sram.SRAM_address;
        sram.SRAM_read_data <= mem[rd_q];
        if (pl_vld) mem[pl_addr] <= pl_dat;
        else if (!sram.SRAM_we_n) mem[sram.SRAM_address] <= sram.SRAM_write_data;
    end

    typedef struct {
        logic [15:0] w0, w1, w2;
        logic [15:0] y;
        logic [7:0]  u, v;
    } vec_t;

    vec_t        vec [NP];
    logic [17:0] exp_log [8];
    logic [17:0] wlog [16];
    int          wcnt;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc, welow;
    logic [17:0] first_addr;
    bit          found;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_dat  = d;
        pl_vld  = 1'b1;
        @(negedge Clock);
        pl_vld  = 1'b0;
    endtask

    // Starts one image and follows it until Done (bounded); Enable stays high when hold is set.
    task automatic run_image(input bit hold);
        cyc = 0;
        welow = 0;
        wcnt = 0;
        first_addr = '0;
        Enable = 1'b1;
        while (cyc < 400) begin
            @(negedge Clock);
            cyc++;
            if (!hold) Enable = 1'b0;
            if (cyc == 1) first_addr = sram.SRAM_address;
            if (!sram.SRAM_we_n) begin
                welow++;
                if (wcnt < 16) begin
                    wlog[wcnt] = sram.SRAM_address;
                    wcnt++;
                end
            end
            if (Done) break;
        end
        // Enable is still high across the edge that ends Done's cycle
        @(posedge Clock);
        #1 Enable = 1'b0;
        @(negedge Clock);
        check("done_one_cycle", 32'(Done), 32'd0);
    endtask

    task automatic check_image(input string tag);
        check({tag, "_cycles"}, 32'(cyc), 32'd53);
        check({tag, "_we_low"}, 32'(welow), 32'd8);
        check({tag, "_first_rd"}, 32'(first_addr), 32'(RGB_BASE));
        for (int i = 0; i < NP; i++)
            check($sformatf("%s_y%0d", tag, i), 32'(mem[Y_BASE + 18'(i)]), 32'(vec[i].y));
        for (int j = 0; j < NP / 2; j++) begin
            check($sformatf("%s_u%0d", tag, j), 32'(mem[U_BASE + 18'(j)]),
                  32'({vec[2*j].u, vec[2*j+1].u}));
            check($sformatf("%s_v%0d", tag, j), 32'(mem[V_BASE + 18'(j)]),
                  32'({vec[2*j].v, vec[2*j+1].v}));
        end
        check({tag, "_wcnt"}, 32'(wcnt), 32'd8);
        for (int k = 0; k < 8; k++)
            check($sformatf("%s_waddr%0d", tag, k), 32'(wlog[k]), 32'(exp_log[k]));
    endtask

    initial begin
        // white/black, red/red, red/white, green/blue
        vec[0] = '{16'hFFFF, 16'hFF00, 16'h0000, 16'hEB10, 8'h80, 8'h80};
        vec[1] = '{16'hFF00, 16'h00FF, 16'h0000, 16'h5252, 8'h5A, 8'hF0};
`ifdef RGB2YUV_AVG_EN
        vec[2] = '{16'hFF00, 16'h00FF, 16'hFFFF, 16'h52EB, 8'h6D, 8'hB8};
        vec[3] = '{16'h00FF, 16'h0000, 16'h00FF, 16'h9129, 8'h93, 8'h48};
`else
        vec[2] = '{16'hFF00, 16'h00FF, 16'hFFFF, 16'h52EB, 8'h5A, 8'hF0};
        vec[3] = '{16'h00FF, 16'h0000, 16'h00FF, 16'h9129, 8'h36, 8'h22};
`endif
        exp_log[0] = 18'd0;     exp_log[1] = 18'd1;
        exp_log[2] = 18'd38400; exp_log[3] = 18'd57600;
        exp_log[4] = 18'd2;     exp_log[5] = 18'd3;
        exp_log[6] = 18'd38401; exp_log[7] = 18'd57601;

        repeat (3) @(negedge Clock);
        check("rst_addr",  32'(sram.SRAM_address), 32'd0);
        check("rst_wdata", 32'(sram.SRAM_write_data), 32'd0);
        check("rst_we_n",  32'(sram.SRAM_we_n), 32'd1);
        check("rst_done",  32'(Done), 32'd0);

        for (int i = 0; i < NP; i++) begin
            preload(RGB_BASE + 18'(3 * i),     vec[i].w0);
            preload(RGB_BASE + 18'(3 * i + 1), vec[i].w1);
            preload(RGB_BASE + 18'(3 * i + 2), vec[i].w2);
        end
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);

        run_image(1'b0);
        check_image("img1");

        // Reset during pair 2 WR_Y must abort without completing the Y write
        preload(Y_BASE + 18'd2, 16'hDEAD);
        preload(U_BASE + 18'd1, 16'hDEAD);
        preload(V_BASE + 18'd1, 16'hDEAD);
        found = 1'b0;
        Enable = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge Clock);
            Enable = 1'b0;
            if (!sram.SRAM_we_n && sram.SRAM_address == Y_BASE + 18'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("found_wr_y_p2", 32'(found), 32'd1);
        Resetn = 1'b0;
        @(negedge Clock);
        check("midrst_addr",  32'(sram.SRAM_address), 32'd0);
        check("midrst_wdata", 32'(sram.SRAM_write_data), 32'd0);
        check("midrst_we_n",  32'(sram.SRAM_we_n), 32'd1);
        check("midrst_done",  32'(Done), 32'd0);
        check("midrst_no_write", 32'(mem[Y_BASE + 18'd2]), 32'h0000DEAD);
        Resetn = 1'b1;
        repeat (3) @(negedge Clock);
        check("post_rst_idle", 32'(sram.SRAM_address), 32'd0);

        // Enable held high for the whole image
        run_image(1'b1);
        check_image("img2");
        repeat (4) @(negedge Clock);
        check("idle_addr_hold", 32'(sram.SRAM_address), 32'(V_BASE + 18'd1));
        check("idle_we_n",      32'(sram.SRAM_we_n), 32'd1);

        Enable = 1'b1;
        @(negedge Clock);
        Enable = 1'b0;
        check("restart_addr", 32'(sram.SRAM_address), 32'(RGB_BASE));
        @(negedge Clock);
        check("restart_addr1", 32'(sram.SRAM_address), 32'(RGB_BASE + 18'd1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
